// File: rtl/code_shift_display.sv
// rtl/code_shift_display.sv - N-digit code shift register with digit count and 7-segment display
// Optional MASK_DISPLAY_EN: occupied positions show a dash instead of the digit.
module code_shift_display #(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    sys_reset,
  input  logic                    clear_code,
  input  logic                    store_digit_pulse,
  input  logic [3:0]              digit_in,
  output logic [4*NUM_DIGITS-1:0] code_value,
  output logic [CNT_W-1:0]        digit_count,
  output logic                    code_ready,
  output logic                    reject_pulse,
  output logic [7*NUM_DIGITS-1:0] hex_segs
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  logic [1:0] state;

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      code_value   <= '0;
      digit_count  <= '0;
      state        <= S_EMPTY;
      code_ready   <= 1'b0;
      reject_pulse <= 1'b0;
    end else begin
      code_ready   <= 1'b0;
      reject_pulse <= 1'b0;
      if (clear_code) begin
        // A store arriving with clear is dropped without a reject.
        code_value  <= '0;
        digit_count <= '0;
        state       <= S_EMPTY;
      end else if (store_digit_pulse) begin
        if (digit_in > 4'd9 || state == S_FULL) begin
          reject_pulse <= 1'b1;
        end else begin
          code_value  <= {code_value[4*NUM_DIGITS-5:0], digit_in};
          digit_count <= digit_count + CNT_W'(1);
          if (digit_count == LAST_SLOT) begin
            state      <= S_FULL;
            code_ready <= 1'b1;
          end else begin
            state <= S_ENTRY;
          end
        end
      end
    end
  end

`ifdef MASK_DISPLAY_EN
  always_comb begin
    hex_segs = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_segs[7*i +: 7] = (int'(digit_count) > i) ? 7'b0111111 : SEG_BLANK;
    end
  end
`else
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    hex_segs = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_segs[7*i +: 7] = (int'(digit_count) > i) ? seg_decode(code_value[4*i +: 4]) : SEG_BLANK;
    end
  end
`endif

endmodule
